// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Receive-side monitor for a multiplexed active-low 7-segment
//                display bus. Debounces {AN,SEG}, decodes each lit glyph back
//                to a hex nibble and reassembles scan frames into a 32-bit
//                value plus an 8-bit digit mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int IDLE_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  AN,
    input  logic [6:0]  SEG,
    output logic [31:0] frame_value,
    output logic [7:0]  frame_mask,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        frame_err,
    output logic        display_off
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int ICW = $clog2(IDLE_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX  = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STAB_FIRE = SCW'(STABLE_CYCLES - 1);
    localparam logic [SCW-1:0] STAB_ONE  = SCW'(1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
    localparam logic [ICW-1:0] IDLE_FIRE = ICW'(IDLE_CYCLES - 1);
    localparam logic [ICW-1:0] IDLE_ONE  = ICW'(1);

    // Synchroniser and previous-cycle copy. These reset to the blank pattern
    // so that reset itself never looks like a multi-hot anode capture.
    logic [7:0]     an_meta, an_s, an_prev;
    logic [6:0]     seg_meta, seg_s, seg_prev;
    logic [SCW-1:0] stab_cnt;
    logic [ICW-1:0] idle_cnt;

    logic [31:0]    work_value;
    logic [7:0]     work_mask;
    logic           work_err;

    logic           same_pat;
    logic           capture;
    logic           idle_hit;
    logic [7:0]     an_low;
    logic           an_onehot;
    logic           an_multi;
    logic [2:0]     digit_idx;
    logic [6:0]     seg_hi;
    logic           glyph_hit;
    logic [3:0]     glyph_nib;
    logic [3:0]     capture_nib;
    logic [31:0]    slot_value;
    logic [7:0]     digit_mask;
    logic [31:0]    commit_value;
    logic           boundary;
    logic           idle_commit;
    logic           commit;

    // Two-flop synchroniser for the display bus plus one delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta  <= 8'hFF;
            an_s     <= 8'hFF;
            an_prev  <= 8'hFF;
            seg_meta <= 7'h7F;
            seg_s    <= 7'h7F;
            seg_prev <= 7'h7F;
        end else begin
            an_meta  <= AN;
            an_s     <= an_meta;
            an_prev  <= an_s;
            seg_meta <= SEG;
            seg_s    <= seg_meta;
            seg_prev <= seg_s;
        end
    end

    assign same_pat = ({an_s, seg_s} == {an_prev, seg_prev});
    // Fires exactly once per stable interval; saturation blocks repeats.
    assign capture  = same_pat && (stab_cnt == STAB_FIRE);
    assign idle_hit = (an_s == 8'hFF) && (idle_cnt == IDLE_FIRE);

    // Stability counter: clears on any pattern change, saturates otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (!same_pat) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + STAB_ONE;
        end
    end

    // Idle counter and display_off flag, both driven by an all-blank anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            display_off <= 1'b0;
        end else if (an_s != 8'hFF) begin
            idle_cnt    <= '0;
            display_off <= 1'b0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_ONE;
            if (idle_cnt == IDLE_FIRE) begin
                display_off <= 1'b1;
            end
        end
    end

    // Anode classification: one-hot-low digit, multi-hot, or blank.
    always_comb begin
        an_low    = ~an_s;
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) begin
                digit_idx = 3'(i);
            end
        end
        an_onehot  = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        an_multi   = (an_low != 8'h00) && !an_onehot;
        digit_mask = 8'h01 << digit_idx;
    end

    // Glyph table lookup on the active-high gfedcba view of SEG.
    always_comb begin
        seg_hi    = ~seg_s;
        glyph_hit = 1'b1;
        glyph_nib = 4'h0;
        case (seg_hi)
            7'h3F: glyph_nib = 4'h0;
            7'h06: glyph_nib = 4'h1;
            7'h5B: glyph_nib = 4'h2;
            7'h4F: glyph_nib = 4'h3;
            7'h66: glyph_nib = 4'h4;
            7'h6D: glyph_nib = 4'h5;
            7'h7D: glyph_nib = 4'h6;
            7'h07: glyph_nib = 4'h7;
            7'h7F: glyph_nib = 4'h8;
            7'h6F: glyph_nib = 4'h9;
            7'h77: glyph_nib = 4'hA;
            7'h7C: glyph_nib = 4'hB;
            7'h39: glyph_nib = 4'hC;
            7'h5E: glyph_nib = 4'hD;
            7'h79: glyph_nib = 4'hE;
            7'h71: glyph_nib = 4'hF;
            default: glyph_hit = 1'b0;
        endcase
        capture_nib = glyph_hit ? glyph_nib : 4'h0;
    end

    // Working value containing only the freshly captured digit.
    always_comb begin
        slot_value = '0;
        slot_value[{digit_idx, 2'b00} +: 4] = capture_nib;
    end

    // Committed value never carries nibbles from digits that were not lit.
    for (genvar g = 0; g < 8; g++) begin : g_mask
        assign commit_value[4*g +: 4] = work_value[4*g +: 4] & {4{work_mask[g]}};
    end

    assign boundary    = capture && an_onehot && work_mask[digit_idx];
    assign idle_commit = idle_hit && (work_mask != 8'h00);
    assign commit      = boundary || idle_commit;

    // Working frame accumulation, restart on boundary, clear on idle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_value <= '0;
            work_mask  <= '0;
            work_err   <= 1'b0;
        end else if (capture && an_onehot) begin
            if (work_mask[digit_idx]) begin
                work_value <= slot_value;
                work_mask  <= digit_mask;
                work_err   <= !glyph_hit;
            end else begin
                work_value[{digit_idx, 2'b00} +: 4] <= capture_nib;
                work_mask[digit_idx]                <= 1'b1;
                work_err                            <= work_err | !glyph_hit;
            end
        end else if (capture && an_multi) begin
            work_err <= 1'b1;
        end else if (idle_commit) begin
            work_value <= '0;
            work_mask  <= '0;
            work_err   <= 1'b0;
        end
    end

    // Commit register and single-cycle valid/changed pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_value   <= '0;
            frame_mask    <= '0;
            frame_err     <= 1'b0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else if (commit) begin
            frame_value   <= commit_value;
            frame_mask    <= work_mask;
            frame_err     <= work_err;
            frame_valid   <= 1'b1;
            frame_changed <= (commit_value != frame_value) || (work_mask != frame_mask);
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_decoder
//  Description : Directed self-checking bench for seg_scan_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic [31:0] frame_value;
    logic [7:0]  frame_mask;
    logic        frame_valid;
    logic        frame_changed;
    logic        frame_err;
    logic        display_off;

    int passed = 0;
    int total  = 0;

    // Observed commit pulses and a snapshot of each commit.
    int          nvalid = 0;
    logic [31:0] snap_value   = '0;
    logic [7:0]  snap_mask    = '0;
    logic        snap_err     = 1'b0;
    logic        snap_changed = 1'b0;

    // Active-high gfedcba glyphs for 0..F.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .IDLE_CYCLES   (1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .AN            (AN),
        .SEG           (SEG),
        .frame_value   (frame_value),
        .frame_mask    (frame_mask),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .frame_err     (frame_err),
        .display_off   (display_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every commit pulse, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) begin
            nvalid       = nvalid + 1;
            snap_value   = frame_value;
            snap_mask    = frame_mask;
            snap_err     = frame_err;
            snap_changed = frame_changed;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic show(input logic [7:0] an, input logic [6:0] seg, input int n);
        AN  = an;
        SEG = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int k, input int g);
        logic [7:0] one;
        one = 8'h01 << k;
        show(~one, ~glyph[g], 8);
    endtask

    task automatic digits(input int first, input int last);
        for (int k = first; k <= last; k++) digit(k, k);
    endtask

    task automatic chk_commit(input string tag, input int cnt, input logic [31:0] v,
                              input logic [7:0] m, input logic e, input logic c);
        chk({tag, "_count"},   nvalid,       cnt);
        chk({tag, "_value"},   snap_value,   v);
        chk({tag, "_mask"},    snap_mask,    m);
        chk({tag, "_err"},     snap_err,     e);
        chk({tag, "_changed"}, snap_changed, c);
    endtask

    initial begin
        rst_n = 1'b0;
        AN    = 8'hFF;
        SEG   = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_value",   frame_value,   32'h0);
        chk("rst_mask",    frame_mask,    8'h00);
        chk("rst_valid",   frame_valid,   1'b0);
        chk("rst_changed", frame_changed, 1'b0);
        chk("rst_err",     frame_err,     1'b0);
        chk("rst_off",     display_off,   1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round 1 fills the working frame; nothing commits yet.
        digits(0, 7);
        chk("r1_no_commit", nvalid, 0);
        chk("r1_off", display_off, 1'b0);

        // Digit 0 of round 2 is the first frame boundary.
        digit(0, 0);
        chk_commit("r2", 1, 32'h76543210, 8'hFF, 1'b0, 1'b1);
        chk("r2_pulse_low", frame_valid, 1'b0);
        digits(1, 7);
        chk("r2_one_commit", nvalid, 1);

        // Identical round: commit with no change.
        digit(0, 0);
        chk_commit("r3", 2, 32'h76543210, 8'hFF, 1'b0, 1'b0);

        // Two-clock glitch between digits 3 and 4 is ignored.
        digits(1, 3);
        show(8'hFE, ~glyph[8], 2);
        digits(4, 7);
        digit(0, 0);
        chk_commit("glitch", 3, 32'h76543210, 8'hFF, 1'b0, 1'b0);

        // Digit 3 shows segment a only: not a glyph.
        digits(1, 2);
        show(8'hF7, 7'b1111110, 8);
        digits(4, 7);
        digit(0, 0);
        chk_commit("badglyph", 4, 32'h76540210, 8'hFF, 1'b1, 1'b1);

        // Multi-hot anode between digits 2 and 3.
        digits(1, 2);
        show(8'hFC, ~glyph[0], 8);
        digits(3, 7);
        digit(0, 0);
        chk_commit("multihot", 5, 32'h76543210, 8'hFF, 1'b1, 1'b1);

        // Blank bus flushes the pending frame that holds only digit 0.
        show(8'hFF, 7'h7F, 1100);
        chk_commit("idle_flush", 6, 32'h00000000, 8'h01, 1'b0, 1'b1);
        chk("idle_flush_off", display_off, 1'b1);

        // Partial scan A,b,C then idle.
        digit(0, 10);
        chk("partial_off_clear", display_off, 1'b0);
        digit(1, 11);
        digit(2, 12);
        chk("partial_no_commit", nvalid, 6);
        show(8'hFF, 7'h7F, 1100);
        chk_commit("partial", 7, 32'h00000CBA, 8'h07, 1'b0, 1'b1);
        chk("partial_off", display_off, 1'b1);

        // Reset in the middle of a frame discards it.
        digit(0, 0);
        chk("resume_off", display_off, 1'b0);
        digits(1, 4);
        chk("prerst_no_commit", nvalid, 7);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_value", frame_value, 32'h0);
        chk("midrst_mask",  frame_mask,  8'h00);
        chk("midrst_err",   frame_err,   1'b0);
        rst_n = 1'b1;
        show(8'hFF, 7'h7F, 1100);
        chk("postrst_no_commit", nvalid, 7);
        chk("postrst_value", frame_value, 32'h0);
        chk("postrst_mask",  frame_mask,  8'h00);
        chk("postrst_err",   frame_err,   1'b0);
        chk("postrst_valid", frame_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
